// File: rtl/sva_sched_pkg.sv
// Shared types for the SVA thread scheduler: controller states, the per-thread
// table entry, and the evaluator's reserved state codes.
package sva_sched_pkg;

    localparam int STATE_W_DEF = 32;
    localparam int TIMER_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        SPAWN_ISSUE,
        SPAWN_WAIT,
        COMMIT
    } ctrl_state_t;

    typedef struct packed {
        logic [TIMER_W_DEF-1:0] start_period;
        logic [STATE_W_DEF-1:0] fsm_cur;
    } sva_thread_t;

    // Two's-complement codes: S0 = 0, SEND = -1, SLAZY = -2
    localparam logic [STATE_W_DEF-1:0] S0    = 32'h0000_0000;
    localparam logic [STATE_W_DEF-1:0] SEND  = 32'hFFFF_FFFF;
    localparam logic [STATE_W_DEF-1:0] SLAZY = 32'hFFFF_FFFE;

endpackage

// File: rtl/sva_gclk_edge_det.sv
// Samples the user clock as data in the sys_clk domain and flags its rising edge.
// grst holds both sample flops cleared, so no edge can be seen while it is high.
module sva_gclk_edge_det (
    input  logic i_sys_clk,
    input  logic i_sys_rst_n,
    input  logic i_gclk,
    input  logic i_grst,
    output logic o_rise
);

    logic r_d0;
    logic r_d1;

    always_ff @(posedge i_sys_clk) begin
        if (!i_sys_rst_n || i_grst) begin
            r_d0 <= 1'b0;
            r_d1 <= 1'b0;
        end else begin
            r_d0 <= i_gclk;
            r_d1 <= r_d0;
        end
    end

    assign o_rise = r_d0 & ~r_d1;

endmodule

// File: rtl/sva_thread_sched.sv
// Per gclk round: replays every live assertion thread through the shared evaluator,
// then one freshly spawned thread, compacting survivors back into the table.
//
// state       | meaning
// IDLE        | waiting for a gclk rise
// ISSUE       | requesting evaluation of slot[rd_idx]
// WAIT        | waiting for that slot's result
// SPAWN_ISSUE | requesting evaluation of a new S0 thread
// SPAWN_WAIT  | waiting for the spawned thread's result
// COMMIT      | publishing the compacted table size
module sva_thread_sched
    import sva_sched_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int STATE_W     = STATE_W_DEF,
    parameter int TIMER_W     = TIMER_W_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           gclk,
    input  logic                           grst,
    input  logic [TIMER_W-1:0]             timer,
    output logic                           eval_req_valid,
    input  logic                           eval_req_ready,
    output logic [STATE_W-1:0]             eval_req_state,
    output logic [TIMER_W-1:0]             eval_req_start,
    input  logic                           eval_rsp_valid,
    input  logic                           eval_rsp_active,
    input  logic [STATE_W-1:0]             eval_rsp_state,
    input  logic                           eval_rsp_succ,
    input  logic                           eval_rsp_fail,
    output logic                           busy,
    output logic [$clog2(NUM_THREADS):0]   live_cnt,
    output logic [CNT_W-1:0]               succ_cnt,
    output logic [CNT_W-1:0]               fail_cnt,
    output logic                           overflow,
    output logic                           missed_edge
);

    localparam int LW = $clog2(NUM_THREADS) + 1;
    localparam int IW = $clog2(NUM_THREADS);
    localparam logic [LW-1:0]    LW_ONE  = 1;
    localparam logic [LW-1:0]    LW_FULL = LW'(NUM_THREADS);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_nxt;
    sva_thread_t      r_slot [NUM_THREADS];
    logic [LW-1:0]    r_snap;
    logic [LW-1:0]    r_rd_idx;
    logic [LW-1:0]    r_wr_idx;
    logic [LW-1:0]    r_live_cnt;
    logic [TIMER_W-1:0] r_spawn_start;
    logic [CNT_W-1:0] r_succ_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_overflow;
    logic             r_missed_edge;

    logic             w_rise;
    logic             w_last_slot;
    logic             w_table_full;
    logic             w_rsp_take;
    sva_thread_t      w_cur;

    sva_gclk_edge_det u_edge_det (
        .i_sys_clk   (sys_clk),
        .i_sys_rst_n (sys_rst_n),
        .i_gclk      (gclk),
        .i_grst      (grst),
        .o_rise      (w_rise)
    );

    assign w_cur        = r_slot[r_rd_idx[IW-1:0]];
    assign w_last_slot  = (r_rd_idx == r_snap - LW_ONE);
    assign w_table_full = (r_wr_idx == LW_FULL);
    assign w_rsp_take   = eval_rsp_valid && ((r_state == WAIT) || (r_state == SPAWN_WAIT));

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:        if (w_rise)         w_state_nxt = (r_live_cnt != '0) ? ISSUE : SPAWN_ISSUE;
            ISSUE:       if (eval_req_ready) w_state_nxt = WAIT;
            WAIT:        if (eval_rsp_valid) w_state_nxt = w_last_slot ? SPAWN_ISSUE : ISSUE;
            SPAWN_ISSUE: if (eval_req_ready) w_state_nxt = SPAWN_WAIT;
            SPAWN_WAIT:  if (eval_rsp_valid) w_state_nxt = COMMIT;
            COMMIT:                          w_state_nxt = IDLE;
            default:                         w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eval_req_valid = 1'b0;
        eval_req_state = '0;
        eval_req_start = '0;
        busy           = 1'b1;
        case (r_state)
            IDLE: busy = 1'b0;
            ISSUE: begin
                eval_req_valid = 1'b1;
                eval_req_state = w_cur.fsm_cur;
                eval_req_start = w_cur.start_period;
            end
            SPAWN_ISSUE: begin
                eval_req_valid = 1'b1;
                eval_req_state = S0;
                eval_req_start = r_spawn_start;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_THREADS; i++) r_slot[i] <= '0;
            r_snap        <= '0;
            r_rd_idx      <= '0;
            r_wr_idx      <= '0;
            r_live_cnt    <= '0;
            r_spawn_start <= '0;
            r_succ_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_overflow    <= 1'b0;
            r_missed_edge <= 1'b0;
        end else begin
            if (r_state == IDLE && w_rise) begin
                r_snap   <= r_live_cnt;
                r_rd_idx <= '0;
                r_wr_idx <= '0;
            end
            if (w_rise && r_state != IDLE) r_missed_edge <= 1'b1;

            // timer is frozen on entry so the spawn request stays stable while stalled
            if (w_state_nxt == SPAWN_ISSUE && r_state != SPAWN_ISSUE) r_spawn_start <= timer;

            // wr_idx never passes rd_idx, so writing in place cannot clobber an unread slot
            if (r_state == WAIT && eval_rsp_valid) begin
                if (eval_rsp_active) begin
                    r_slot[r_wr_idx[IW-1:0]] <= '{start_period: w_cur.start_period,
                                                  fsm_cur:      eval_rsp_state};
                    r_wr_idx <= r_wr_idx + LW_ONE;
                end
                r_rd_idx <= r_rd_idx + LW_ONE;
            end

            if (r_state == SPAWN_WAIT && eval_rsp_valid && eval_rsp_active) begin
                if (w_table_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_slot[r_wr_idx[IW-1:0]] <= '{start_period: r_spawn_start,
                                                  fsm_cur:      eval_rsp_state};
                    r_wr_idx <= r_wr_idx + LW_ONE;
                end
            end

            if (w_rsp_take && eval_rsp_succ && !(&r_succ_cnt)) r_succ_cnt <= r_succ_cnt + CNT_ONE;
            if (w_rsp_take && eval_rsp_fail && !(&r_fail_cnt)) r_fail_cnt <= r_fail_cnt + CNT_ONE;

            if (r_state == COMMIT) r_live_cnt <= r_wr_idx;
        end
    end

    assign live_cnt    = r_live_cnt;
    assign succ_cnt    = r_succ_cnt;
    assign fail_cnt    = r_fail_cnt;
    assign overflow    = r_overflow;
    assign missed_edge = r_missed_edge;

endmodule

// File: tb/tb_sva_thread_sched.sv
// Randomized bench: drives gclk rounds and plays the evaluator, checking every
// request and round result against a queue-based model of the thread table.
module tb_sva_thread_sched;
    import sva_sched_pkg::*;

    localparam int N  = 4;
    localparam int SW = 32;
    localparam int TW = 8;
    localparam int CW = 16;
    localparam int LW = $clog2(N) + 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          gclk = 1'b0;
    logic          grst = 1'b0;
    logic [TW-1:0] timer = '0;
    logic          eval_req_valid;
    logic          eval_req_ready = 1'b0;
    logic [SW-1:0] eval_req_state;
    logic [TW-1:0] eval_req_start;
    logic          eval_rsp_valid = 1'b0;
    logic          eval_rsp_active = 1'b0;
    logic [SW-1:0] eval_rsp_state = '0;
    logic          eval_rsp_succ = 1'b0;
    logic          eval_rsp_fail = 1'b0;
    logic          busy;
    logic [LW-1:0] live_cnt;
    logic [CW-1:0] succ_cnt;
    logic [CW-1:0] fail_cnt;
    logic          overflow;
    logic          missed_edge;

    sva_thread_sched #(.NUM_THREADS(N), .STATE_W(SW), .TIMER_W(TW), .CNT_W(CW)) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .gclk            (gclk),
        .grst            (grst),
        .timer           (timer),
        .eval_req_valid  (eval_req_valid),
        .eval_req_ready  (eval_req_ready),
        .eval_req_state  (eval_req_state),
        .eval_req_start  (eval_req_start),
        .eval_rsp_valid  (eval_rsp_valid),
        .eval_rsp_active (eval_rsp_active),
        .eval_rsp_state  (eval_rsp_state),
        .eval_rsp_succ   (eval_rsp_succ),
        .eval_rsp_fail   (eval_rsp_fail),
        .busy            (busy),
        .live_cnt        (live_cnt),
        .succ_cnt        (succ_cnt),
        .fail_cnt        (fail_cnt),
        .overflow        (overflow),
        .missed_edge     (missed_edge)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { logic [31:0] st; logic [7:0] sp; } thr_t;

    thr_t        m_tbl[$];
    logic [15:0] m_succ = '0;
    logic [15:0] m_fail = '0;
    bit          m_ovf = 1'b0;
    bit          m_missed = 1'b0;
    int          m_acc = 0;
    int          n_acc = 0;
    int          mode = 0;
    int          spawn_k = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge sys_clk)
        if (sys_rst_n && eval_req_valid && eval_req_ready) n_acc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Evaluator behaviour for each scenario, expressed purely on thread state codes.
    task automatic eval_rule(input logic [31:0] st, output bit act, output logic [31:0] nst,
                             output bit sc, output bit fl);
        act = 1'b0; nst = $urandom; sc = 1'b0; fl = 1'b0;
        case (mode)
            0: begin fl = 1'b1; nst = SLAZY; end
            1: if (st == 0) begin act = 1'b1; nst = 5; end
               else begin sc = 1'b1; nst = SEND; end
            2: begin act = 1'b1; nst = st + 1; sc = 1'($urandom_range(0, 1)); fl = 1'($urandom_range(0, 1)); end
            3: if (st == 0) begin act = 1'b1; nst = 7 + 2 * spawn_k; spawn_k++; end
               else if (st == 9) fl = 1'b1;
               else if (st >= 100) begin act = 1'b1; nst = st; end
               else begin act = 1'b1; nst = st + 100; end
            default: begin
                act = ($urandom_range(0, 3) != 0);
                nst = $urandom_range(1, 1000);
                sc  = 1'($urandom_range(0, 1));
                fl  = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (eval_req_valid) begin ok = 1'b1; break; end
            @(negedge sys_clk);
        end
        if (!ok) chk("req_timeout", eval_req_valid, 1);
    endtask

    task automatic model_reset();
        m_tbl.delete();
        m_succ = '0; m_fail = '0; m_ovf = 1'b0; m_missed = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        model_reset();
        tick(1);
    endtask

    task automatic check_stats(input string pfx);
        chk({pfx, "_live"}, live_cnt, m_tbl.size());
        chk({pfx, "_succ"}, succ_cnt, m_succ);
        chk({pfx, "_fail"}, fail_cnt, m_fail);
        chk({pfx, "_ovf"},  overflow, m_ovf);
        chk({pfx, "_miss"}, missed_edge, m_missed);
    endtask

    task automatic do_round(input bit inject);
        thr_t        nt[$];
        logic [7:0]  t0, esp;
        logic [31:0] est, nst;
        bit          ok, act, sc, fl;
        int          n;
        t0    = 8'($urandom);
        timer = t0;
        gclk  = 1'b1;
        n     = m_tbl.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin est = m_tbl[i].st; esp = m_tbl[i].sp; end
            else       begin est = 0;           esp = t0;          end
            wait_valid(ok);
            if (!ok) begin gclk = 1'b0; return; end
            chk("req_state", eval_req_state, est);
            chk("req_start", eval_req_start, esp);
            if (i == 0) begin chk("busy_in_round", busy, 1); gclk = 1'b0; end
            if (i == n) timer = 8'($urandom);
            if (inject && i == 0) begin
                tick(2); gclk = 1'b1; tick(3); gclk = 1'b0; tick(5);
            end else begin
                tick($urandom_range(0, 3));
            end
            chk("req_hold_valid", eval_req_valid, 1);
            chk("req_hold_state", eval_req_state, est);
            chk("req_hold_start", eval_req_start, esp);
            eval_req_ready = 1'b1;
            tick(1);
            eval_req_ready = 1'b0;
            m_acc++;
            tick($urandom_range(0, 2));
            eval_rule(est, act, nst, sc, fl);
            eval_rsp_valid = 1'b1; eval_rsp_active = act; eval_rsp_state = nst;
            eval_rsp_succ = sc; eval_rsp_fail = fl;
            tick(1);
            eval_rsp_valid = 1'b0; eval_rsp_active = 1'($urandom); eval_rsp_state = $urandom;
            eval_rsp_succ = 1'($urandom); eval_rsp_fail = 1'($urandom);
            if (act) begin
                if (i < n)               nt.push_back('{st: nst, sp: m_tbl[i].sp});
                else if (nt.size() < N)  nt.push_back('{st: nst, sp: t0});
                else                     m_ovf = 1'b1;
            end
            if (sc && m_succ != 16'hFFFF) m_succ++;
            if (fl && m_fail != 16'hFFFF) m_fail++;
        end
        m_tbl = nt;
        if (inject) m_missed = 1'b1;
        for (int i = 0; i < 20 && busy; i++) tick(1);
        chk("round_end_busy", busy, 0);
        check_stats("round");
    endtask

    initial begin
        bit ok;
        tick(3);
        chk("rst_busy",  busy, 0);
        chk("rst_valid", eval_req_valid, 0);
        check_stats("rst");
        sys_rst_n = 1'b1;
        tick(2);

        mode = 0;
        do_round(1'b0);

        do_reset(); mode = 1;
        repeat (3) do_round(1'b0);

        do_reset(); mode = 2;
        repeat (5) do_round(1'b0);

        do_reset(); mode = 2;
        do_round(1'b1);
        tick(10);
        chk("miss_idle_busy", busy, 0);
        chk("miss_accepts", n_acc, m_acc);

        do_reset(); mode = 3; spawn_k = 0;
        repeat (6) do_round(1'b0);

        grst = 1'b1;
        tick(1);
        gclk = 1'b1;
        tick(5);
        chk("grst_busy", busy, 0);
        gclk = 1'b0;
        tick(2);
        grst = 1'b0;
        tick(4);
        chk("grst_busy_after", busy, 0);
        chk("grst_accepts", n_acc, m_acc);
        do_round(1'b0);

        do_reset(); mode = 2;
        repeat (2) do_round(1'b0);
        gclk = 1'b1;
        wait_valid(ok);
        gclk = 1'b0;
        eval_req_ready = 1'b1;
        tick(1);
        eval_req_ready = 1'b0;
        m_acc++;
        tick(20);
        chk("stuck_busy",   busy, 1);
        chk("stuck_no_req", eval_req_valid, 0);
        do_reset();
        eval_rsp_valid = 1'b1; eval_rsp_active = 1'b1; eval_rsp_succ = 1'b1; eval_rsp_fail = 1'b1;
        tick(1);
        eval_rsp_valid = 1'b0;
        tick(3);
        chk("stale_busy",  busy, 0);
        chk("stale_valid", eval_req_valid, 0);
        check_stats("stale");
        do_round(1'b0);

        do_reset(); mode = 4;
        repeat (40) do_round(1'b0);

        tick(5);
        chk("total_accepts", n_acc, m_acc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
